// File: rtl/pattern_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pattern_sequencer_pkg
//   Shared definitions for the test-pattern sequencer: FSM state encoding,
//   on-screen selection marker geometry and a counter-width helper.
// ---------------------------------------------------------------------------
package pattern_sequencer_pkg;

   // Fixed encodings so the state can be probed/compared outside this block.
   typedef enum logic [1:0] {
      SHOW    = 2'd0,
      PENDING = 2'd1,
      MUTE    = 2'd2
   } seq_state_t;

   // Selection marker: a bar OSD_LINES tall and OSD_STEP*(sel+1) pixels wide.
   localparam int OSD_LINES = 4;
   localparam int OSD_STEP  = 8;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
//   Rising-edge detector for a signal already synchronous to clk (vsync,
//   hsync). The input is delayed by one register; rise is high for the one
//   clock cycle in which sig is 1 and its delayed copy is still 0.
// Ports
//   clk    in  clock
//   reset  in  asynchronous, active-low reset (clears the delay register)
//   sig    in  level to watch
//   rise   out one-cycle pulse on a 0->1 transition of sig
// ---------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_d_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig_d_reg <= 1'b0;
      end else begin
         sig_d_reg <= sig;
      end
   end

   assign rise = sig & ~sig_d_reg;

endmodule

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//   Shares one rgb output between NUM_PATTERNS test-pattern generators.
//   Selection changes only on a frame tick (rising vsync), so frames are
//   never torn. A switch raises pattern_restart for one clock so the
//   generators can resync, and can blank MUTE_FRAMES following frames.
//   Switch sources: next_req (step), sel_valid/sel_idx (direct), and a timed
//   auto-cycle (auto_en, DWELL_FRAMES frames per pattern).
// Ports
//   clk             in  pixel clock
//   reset           in  asynchronous, active-low reset
//   vsync           in  vertical sync, active high
//   display_on      in  visible-region flag
//   hpos, vpos      in  beam position (9 bits each)
//   pat_rgb         in  generator i colour at [3*i +: 3]
//   auto_en         in  level, enables timed auto-cycle
//   next_req        in  1-clk pulse, step to next pattern
//   sel_valid       in  1-clk pulse, direct-select request
//   sel_idx         in  direct-select target
//   rgb             out registered, muxed video (1 clk after hpos/vpos)
//   pattern_sel     out currently displayed pattern
//   pattern_restart out 1-clk pulse when a new selection takes effect
//   pending         out a switch is waiting for the next frame tick
// ---------------------------------------------------------------------------
module pattern_sequencer
   import pattern_sequencer_pkg::*;
#(
   parameter  int NUM_PATTERNS = 4,
   parameter  int DWELL_FRAMES = 60,
   parameter  int MUTE_FRAMES  = 1,
   parameter  int OSD_EN       = 1,
   localparam int SELW         = $clog2(NUM_PATTERNS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vsync,
   input  logic                      display_on,
   input  logic [8:0]                hpos,
   input  logic [8:0]                vpos,
   input  logic [3*NUM_PATTERNS-1:0] pat_rgb,
   input  logic                      auto_en,
   input  logic                      next_req,
   input  logic                      sel_valid,
   input  logic [SELW-1:0]           sel_idx,
   output logic [2:0]                rgb,
   output logic [SELW-1:0]           pattern_sel,
   output logic                      pattern_restart,
   output logic                      pending
);

   localparam int DWW = cnt_width(DWELL_FRAMES);
   localparam int MW  = cnt_width(MUTE_FRAMES);

   localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL_FRAMES - 1);
   localparam logic [MW-1:0]   MUTE_LOAD  = (MUTE_FRAMES > 0) ? MW'(MUTE_FRAMES - 1) : '0;
   localparam logic [SELW-1:0] SEL_LAST   = SELW'(NUM_PATTERNS - 1);

   seq_state_t      state_reg, state_next;
   logic [SELW-1:0] sel_reg, sel_next;
   logic [SELW-1:0] target_reg, target_next;
   logic [DWW-1:0]  dwell_reg, dwell_next;
   logic [MW-1:0]   mute_reg, mute_next;
   logic            restart_reg, restart_next;
   logic [2:0]      rgb_reg, rgb_next;

   logic            frame_tick;
   logic            sel_ok;
   logic [SELW-1:0] sel_inc;
   logic            do_switch;
   logic [SELW-1:0] switch_to;

   // Generator colours unpacked so the mux indexes by pattern number.
   logic [2:0] pat_arr [NUM_PATTERNS];

   generate
      for (genvar gi = 0; gi < NUM_PATTERNS; gi++) begin : g_unpack
         assign pat_arr[gi] = pat_rgb[3*gi +: 3];
      end
   endgenerate

   sync_edge_detect u_vsync_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (vsync),
      .rise  (frame_tick)
   );

   // Out-of-range direct selects are dropped outright.
   assign sel_ok  = sel_valid && (int'(sel_idx) < NUM_PATTERNS);
   assign sel_inc = (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= SHOW;
         sel_reg     <= '0;
         target_reg  <= '0;
         dwell_reg   <= '0;
         mute_reg    <= '0;
         restart_reg <= 1'b0;
         rgb_reg     <= 3'b000;
      end else begin
         state_reg   <= state_next;
         sel_reg     <= sel_next;
         target_reg  <= target_next;
         dwell_reg   <= dwell_next;
         mute_reg    <= mute_next;
         restart_reg <= restart_next;
         rgb_reg     <= rgb_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      sel_next     = sel_reg;
      target_next  = target_reg;
      dwell_next   = dwell_reg;
      mute_next    = mute_reg;
      restart_next = 1'b0;
      do_switch    = 1'b0;
      switch_to    = target_reg;

      case (state_reg)
         SHOW: begin
            // A request always wins over dwell expiry on the same cycle and is
            // only latched, even when it coincides with a frame tick.
            if (sel_ok) begin
               target_next = sel_idx;
               state_next  = PENDING;
            end else if (next_req) begin
               target_next = sel_inc;
               state_next  = PENDING;
            end else if (frame_tick && auto_en) begin
               if (dwell_reg == DWELL_LAST) begin
                  do_switch = 1'b1;
                  switch_to = sel_inc;
               end else begin
                  dwell_next = dwell_reg + 1'b1;
               end
            end
         end
         PENDING: begin
            // Latest direct select is the one that takes effect, including one
            // that lands on the tick itself.
            if (sel_ok) begin
               target_next = sel_idx;
            end
            if (frame_tick) begin
               do_switch = 1'b1;
               switch_to = target_next;
            end
         end
         MUTE: begin
            if (frame_tick) begin
               if (mute_reg == '0) begin
                  state_next = SHOW;
               end else begin
                  mute_next = mute_reg - 1'b1;
               end
            end
         end
         default: begin
            state_next = SHOW;
         end
      endcase

      // Re-selecting the current pattern still restarts the generators.
      if (do_switch) begin
         sel_next     = switch_to;
         target_next  = switch_to;
         restart_next = 1'b1;
         dwell_next   = '0;
         if (MUTE_FRAMES > 0) begin
            mute_next  = MUTE_LOAD;
            state_next = MUTE;
         end else begin
            state_next = SHOW;
         end
      end
   end

   always_comb begin
      rgb_next = pat_arr[sel_reg];
      if (!display_on || state_reg == MUTE) begin
         rgb_next = 3'b000;
      end else if ((OSD_EN != 0) && (int'(vpos) < OSD_LINES) &&
                   (int'(hpos) < OSD_STEP * (int'(sel_reg) + 1))) begin
         rgb_next = 3'b111;
      end
   end

   assign rgb             = rgb_reg;
   assign pattern_sel     = sel_reg;
   assign pattern_restart = restart_reg;
   assign pending         = (state_reg == PENDING);

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

   // Short stub frames: 48 clocks/line (40 visible), 10 lines (8 visible),
   // vsync high for the whole of line 8.
   localparam int H_TOT = 48;
   localparam int H_VIS = 40;
   localparam int V_TOT = 10;
   localparam int V_VIS = 8;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int BOUND = 2 * FRAME + 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [8:0] hpos = '0;
   logic [8:0] vpos = '0;
   logic       vsync, display_on;

   always @(posedge clk) begin
      if (hpos == 9'(H_TOT - 1)) begin
         hpos <= '0;
         vpos <= (vpos == 9'(V_TOT - 1)) ? 9'd0 : vpos + 9'd1;
      end else begin
         hpos <= hpos + 9'd1;
      end
   end
   assign display_on = (hpos < 9'(H_VIS)) && (vpos < 9'(V_VIS));
   assign vsync      = (vpos == 9'(V_VIS));

   // 4-pattern instance: DWELL 2, one mute frame, marker on.
   logic        auto_en = 1'b0, next_req = 1'b0, sel_valid = 1'b0;
   logic [1:0]  sel_idx = '0;
   logic [11:0] pat4 = {3'd3, 3'd2, 3'd1, 3'd0};
   logic [2:0]  rgb4;
   logic [1:0]  sel4;
   logic        restart4, pending4;

   pattern_sequencer #(
      .NUM_PATTERNS (4),
      .DWELL_FRAMES (2),
      .MUTE_FRAMES  (1),
      .OSD_EN       (1)
   ) u_dut4 (
      .clk             (clk),
      .reset           (reset),
      .vsync           (vsync),
      .display_on      (display_on),
      .hpos            (hpos),
      .vpos            (vpos),
      .pat_rgb         (pat4),
      .auto_en         (auto_en),
      .next_req        (next_req),
      .sel_valid       (sel_valid),
      .sel_idx         (sel_idx),
      .rgb             (rgb4),
      .pattern_sel     (sel4),
      .pattern_restart (restart4),
      .pending         (pending4)
   );

   // 5-pattern instance: out-of-range indices representable, no mute, no marker.
   logic        auto_en5 = 1'b0, next_req5 = 1'b0, sel_valid5 = 1'b0;
   logic [2:0]  sel_idx5 = '0;
   logic [14:0] pat5 = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
   logic [2:0]  rgb5;
   logic [2:0]  sel5;
   logic        restart5, pending5;

   pattern_sequencer #(
      .NUM_PATTERNS (5),
      .DWELL_FRAMES (3),
      .MUTE_FRAMES  (0),
      .OSD_EN       (0)
   ) u_dut5 (
      .clk             (clk),
      .reset           (reset),
      .vsync           (vsync),
      .display_on      (display_on),
      .hpos            (hpos),
      .vpos            (vpos),
      .pat_rgb         (pat5),
      .auto_en         (auto_en5),
      .next_req        (next_req5),
      .sel_valid       (sel_valid5),
      .sel_idx         (sel_idx5),
      .rgb             (rgb5),
      .pattern_sel     (sel5),
      .pattern_restart (restart5),
      .pending         (pending5)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int rc4 = 0;
   int rc5 = 0;

   // Count clock cycles with restart high; a proper pulse adds exactly one.
   always @(negedge clk) begin
      if (restart4 === 1'b1) rc4++;
      if (restart5 === 1'b1) rc5++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   // Advance to the next negedge at which the stub beam is at (v,h).
   task automatic goto(input int v, input int h);
      bit found = 1'b0;
      for (int n = 0; n < BOUND && !found; n++) begin
         @(negedge clk);
         if (int'(vpos) == v && int'(hpos) == h) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL goto: beam (%0d,%0d) not reached within %0d cycles", v, h, BOUND);
      end
   endtask

   // rgb for pixel (v,h) appears one clock after the beam is there.
   task automatic sample_rgb(input int v, input int h, output logic [2:0] r4, output logic [2:0] r5);
      goto(v, h);
      @(negedge clk);
      r4 = rgb4;
      r5 = rgb5;
   endtask

   typedef struct {
      bit         use_sel;   // 1: direct select, 0: next_req
      logic [1:0] idx;
      logic [1:0] exp_sel;
      int         osd_edge;  // first hpos past the marker
      logic [2:0] exp_rgb;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [2:0] r4, r5;
      int rc_snap, rc5_snap;

      vecs[0] = '{use_sel: 1'b0, idx: 2'd0, exp_sel: 2'd1, osd_edge: 16, exp_rgb: 3'd1};
      vecs[1] = '{use_sel: 1'b1, idx: 2'd3, exp_sel: 2'd3, osd_edge: 32, exp_rgb: 3'd3};
      vecs[2] = '{use_sel: 1'b0, idx: 2'd0, exp_sel: 2'd0, osd_edge: 8,  exp_rgb: 3'd0};
      vecs[3] = '{use_sel: 1'b1, idx: 2'd2, exp_sel: 2'd2, osd_edge: 24, exp_rgb: 3'd2};
      vecs[4] = '{use_sel: 1'b1, idx: 2'd2, exp_sel: 2'd2, osd_edge: 24, exp_rgb: 3'd2};

      // ---- reset state
      repeat (3) @(negedge clk);
      check("reset rgb", rgb4, 0);
      check("reset pattern_sel", sel4, 0);
      check("reset restart", restart4, 0);
      check("reset pending", pending4, 0);
      reset = 1'b1;

      // ---- three idle frames on pattern 0
      for (int f = 0; f < 3; f++) begin
         sample_rgb(1, 7, r4, r5);
         check($sformatf("idle f%0d osd", f), r4, 7);
         sample_rgb(5, 10, r4, r5);
         check($sformatf("idle f%0d rgb", f), r4, 0);
         check($sformatf("idle f%0d sel", f), sel4, 0);
      end
      check("idle restart count", rc4, 0);

      // ---- table-driven switches
      for (int i = 0; i < 5; i++) begin
         goto(2, 5);
         if (vecs[i].use_sel) begin
            sel_valid = 1'b1;
            sel_idx   = vecs[i].idx;
         end else begin
            next_req = 1'b1;
         end
         @(negedge clk);
         sel_valid = 1'b0;
         next_req  = 1'b0;
         rc_snap   = rc4;
         check($sformatf("v%0d pending after req", i), pending4, 1);
         goto(8, 3);
         check($sformatf("v%0d sel at tick", i), sel4, vecs[i].exp_sel);
         check($sformatf("v%0d restart pulses", i), rc4 - rc_snap, 1);
         check($sformatf("v%0d pending after tick", i), pending4, 0);
         sample_rgb(5, 10, r4, r5);
         check($sformatf("v%0d muted frame", i), r4, 0);
         sample_rgb(1, vecs[i].osd_edge - 1, r4, r5);
         check($sformatf("v%0d osd inside", i), r4, 7);
         sample_rgb(1, vecs[i].osd_edge, r4, r5);
         check($sformatf("v%0d osd edge", i), r4, vecs[i].exp_rgb);
         sample_rgb(5, 10, r4, r5);
         check($sformatf("v%0d colour", i), r4, vecs[i].exp_rgb);
      end

      // ---- simultaneous sel_valid + next_req: direct select wins
      goto(2, 5);
      sel_valid = 1'b1; sel_idx = 2'd3; next_req = 1'b1;
      @(negedge clk);
      sel_valid = 1'b0; next_req = 1'b0;
      check("prio pending", pending4, 1);
      goto(8, 3);
      check("prio sel", sel4, 3);
      sample_rgb(5, 10, r4, r5);   // muted frame passes

      // ---- PENDING: sel_valid overwrites target, next_req ignored
      goto(2, 5);
      next_req = 1'b1;
      @(negedge clk);
      next_req = 1'b0;
      goto(3, 5);
      sel_valid = 1'b1; sel_idx = 2'd2;
      @(negedge clk);
      sel_valid = 1'b0;
      goto(4, 5);
      next_req = 1'b1;
      @(negedge clk);
      next_req = 1'b0;
      check("overwrite pending", pending4, 1);
      rc_snap = rc4;
      goto(8, 3);
      check("overwrite sel", sel4, 2);
      check("overwrite restart", rc4 - rc_snap, 1);
      sample_rgb(5, 10, r4, r5);
      check("overwrite muted", r4, 0);
      sample_rgb(5, 10, r4, r5);
      check("overwrite colour", r4, 2);

      // ---- auto-cycle from pattern 3, DWELL 2
      goto(2, 5);
      next_req = 1'b1;
      @(negedge clk);
      next_req = 1'b0;
      goto(8, 3);
      check("auto pre sel", sel4, 3);
      sample_rgb(5, 10, r4, r5);   // muted frame passes
      goto(2, 5);
      auto_en = 1'b1;
      rc_snap = rc4;
      goto(8, 3);
      check("auto tick1 sel", sel4, 3);
      check("auto tick1 restart", rc4 - rc_snap, 0);
      goto(8, 3);
      check("auto tick2 sel", sel4, 0);
      check("auto tick2 restart", rc4 - rc_snap, 1);
      auto_en = 1'b0;
      rc_snap = rc4;
      for (int f = 0; f < 5; f++) goto(8, 3);
      check("auto off sel", sel4, 0);
      check("auto off restart", rc4 - rc_snap, 0);
      sample_rgb(1, 8, r4, r5);
      check("auto off osd edge", r4, 0);

      // ---- reset while in MUTE
      goto(2, 5);
      next_req = 1'b1;
      @(negedge clk);
      next_req = 1'b0;
      goto(8, 3);
      check("rst pre sel", sel4, 1);
      sample_rgb(3, 5, r4, r5);
      check("rst pre muted", r4, 0);
      #2 reset = 1'b0;
      #1;
      check("rst async sel", sel4, 0);
      check("rst async pending", pending4, 0);
      check("rst async restart", restart4, 0);
      check("rst async rgb", rgb4, 0);
      @(negedge clk);
      reset = 1'b1;
      rc_snap  = rc4;
      rc5_snap = rc5;
      sample_rgb(1, 7, r4, r5);
      check("rst after osd", r4, 7);
      sample_rgb(1, 8, r4, r5);
      check("rst after colour", r4, 0);
      check("rst after no restart", rc4 - rc_snap, 0);

      // ---- 5-pattern instance: invalid indices, no mute, mod-5 wrap
      goto(2, 5);
      sel_valid5 = 1'b1; sel_idx5 = 3'd5;
      @(negedge clk);
      sel_valid5 = 1'b0;
      check("n5 idx5 ignored", pending5, 0);
      goto(3, 5);
      sel_valid5 = 1'b1; sel_idx5 = 3'd7;
      @(negedge clk);
      sel_valid5 = 1'b0;
      check("n5 idx7 ignored", pending5, 0);
      goto(8, 3);
      check("n5 sel unchanged", sel5, 0);
      check("n5 no restart", rc5 - rc5_snap, 0);
      goto(2, 5);
      sel_valid5 = 1'b1; sel_idx5 = 3'd4;
      @(negedge clk);
      sel_valid5 = 1'b0;
      check("n5 idx4 pending", pending5, 1);
      goto(8, 3);
      check("n5 sel 4", sel5, 4);
      check("n5 restart", rc5 - rc5_snap, 1);
      sample_rgb(1, 3, r4, r5);
      check("n5 no mute no osd", r5, 4);
      goto(2, 5);
      next_req5 = 1'b1;
      @(negedge clk);
      next_req5 = 1'b0;
      goto(8, 3);
      check("n5 wrap sel", sel5, 0);
      check("n5 wrap restart", rc5 - rc5_snap, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
